// File: rtl/rgb565_serializer.sv
// Serialises RGB565 pixels into two bytes each over a valid/ready byte stream.
// Optional RGB565_SER_LAST_EN adds byt_lst, flagging the final byte of each LINE_PX-pixel line.
module rgb565_serializer #(
  parameter int unsigned LINE_PX    = 640,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_vld,
  input  logic [4:0] pix_r,
  input  logic [5:0] pix_g,
  input  logic [4:0] pix_b,
  output logic       pix_rdy,
  output logic       byt_vld,
  output logic [7:0] byt_dat,
  input  logic       byt_rdy
`ifdef RGB565_SER_LAST_EN
  ,
  output logic       byt_lst
`endif
);

  if (LINE_PX < 1) begin : g_bad_line_px
    $error("LINE_PX must be at least 1");
  end

  typedef enum logic [1:0] {StEmpty, StB0, StB1} state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q;
  logic        pix_acc;
  logic [7:0]  first_byte, second_byte;

  assign first_byte  = BIG_ENDIAN ? word_q[15:8] : word_q[7:0];
  assign second_byte = BIG_ENDIAN ? word_q[7:0]  : word_q[15:8];

  always_comb begin
    pix_rdy = (state_q == StEmpty) || ((state_q == StB1) && byt_rdy);
    pix_acc = pix_vld && pix_rdy;
    byt_vld = (state_q != StEmpty);
    // Outside B1 the first byte of the held word is shown, which reads 0x00 after reset.
    byt_dat = (state_q == StB1) ? second_byte : first_byte;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (pix_vld) state_d = StB0;
      StB0:    if (byt_rdy) state_d = StB1;
      StB1:    if (byt_rdy) state_d = pix_vld ? StB0 : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pix_acc) word_q <= {pix_r, pix_g, pix_b};
    end
  end

`ifdef RGB565_SER_LAST_EN
  localparam int unsigned    CntW    = (LINE_PX > 1) ? $clog2(LINE_PX) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LINE_PX - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == StB1) && byt_rdy) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
    byt_lst = (state_q == StB1) && (cnt_q == LastCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_rgb565_serializer.sv
// Bench for rgb565_serializer: directed vector table, reset corner case and a
// randomised run checked against a queue-based byte-stream model.
module tb_rgb565_serializer;

  localparam int unsigned LinePx = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_vld;
  logic [4:0] pix_r;
  logic [5:0] pix_g;
  logic [4:0] pix_b;
  logic       byt_rdy;
  logic       rdy_be, vld_be, rdy_le, vld_le;
  logic [7:0] dat_be, dat_le;
  logic       lst_be, lst_le;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgb565_serializer #(.LINE_PX(LinePx), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_rdy(rdy_be), .byt_vld(vld_be), .byt_dat(dat_be), .byt_rdy(byt_rdy)
`ifdef RGB565_SER_LAST_EN
    , .byt_lst(lst_be)
`endif
  );

  rgb565_serializer #(.LINE_PX(LinePx), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_rdy(rdy_le), .byt_vld(vld_le), .byt_dat(dat_le), .byt_rdy(byt_rdy)
`ifdef RGB565_SER_LAST_EN
    , .byt_lst(lst_le)
`endif
  );

`ifndef RGB565_SER_LAST_EN
  assign lst_be = 1'b0;
  assign lst_le = 1'b0;
`endif

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [15:0] w, input logic rdy);
    pix_vld = vld;
    {pix_r, pix_g, pix_b} = w;
    byt_rdy = rdy;
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] w, input bit be, input int half);
    logic [7:0] hi, lo;
    hi = w[15:8];
    lo = w[7:0];
    if (half == 0) return be ? hi : lo;
    return be ? lo : hi;
  endfunction

  typedef struct {
    logic        vld;
    logic [15:0] w;
    logic        rdy;
    logic        e_prdy;
    logic        e_bvld;
    logic [7:0]  e_be;
    logic [7:0]  e_le;
    logic        e_lst;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic vld, input logic [15:0] w, input logic rdy,
                              input logic e_prdy, input logic e_bvld, input logic [7:0] e_be,
                              input logic [7:0] e_le, input logic e_lst);
    vec_t v;
    v.vld = vld; v.w = w; v.rdy = rdy; v.e_prdy = e_prdy; v.e_bvld = e_bvld;
    v.e_be = e_be; v.e_le = e_le; v.e_lst = e_lst;
    return v;
  endfunction

  task automatic check_idle_reset(input string tag);
    chk({tag, "_bvld_be"}, {7'd0, vld_be}, 8'd0);
    chk({tag, "_bvld_le"}, {7'd0, vld_le}, 8'd0);
    chk({tag, "_prdy_be"}, {7'd0, rdy_be}, 8'd1);
    chk({tag, "_prdy_le"}, {7'd0, rdy_le}, 8'd1);
    chk({tag, "_dat_be"}, dat_be, 8'h00);
    chk({tag, "_dat_le"}, dat_le, 8'h00);
`ifdef RGB565_SER_LAST_EN
    chk({tag, "_lst"}, {7'd0, lst_be}, 8'd0);
`endif
  endtask

  logic [15:0] wq[$];
  int          half;
  int          pixdone;

  initial begin
    // Cycle-by-cycle vectors; outputs are what should be seen during that cycle.
    tbl[0]  = mk(1, 16'h8E43, 1, 1, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 16'h0000, 1, 0, 1, 8'h8E, 8'h43, 0);
    tbl[2]  = mk(0, 16'h0000, 1, 1, 1, 8'h43, 8'h8E, 0);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 0);
    tbl[4]  = mk(1, 16'hFFFF, 1, 1, 0, 8'h00, 8'h00, 0);
    tbl[5]  = mk(1, 16'h0000, 1, 0, 1, 8'hFF, 8'hFF, 0);
    tbl[6]  = mk(1, 16'h0000, 1, 1, 1, 8'hFF, 8'hFF, 1);
    tbl[7]  = mk(1, 16'h0001, 1, 0, 1, 8'h00, 8'h00, 0);
    tbl[8]  = mk(1, 16'h0001, 1, 1, 1, 8'h00, 8'h00, 0);
    tbl[9]  = mk(0, 16'h0000, 1, 0, 1, 8'h00, 8'h01, 0);
    tbl[10] = mk(0, 16'h0000, 1, 1, 1, 8'h01, 8'h00, 1);
    tbl[11] = mk(0, 16'h0000, 1, 1, 0, 8'h00, 8'h00, 0);
    tbl[12] = mk(1, 16'h8E43, 0, 1, 0, 8'h00, 8'h00, 0);
    tbl[13] = mk(0, 16'h5555, 0, 0, 1, 8'h8E, 8'h43, 0);
    tbl[14] = mk(1, 16'h1234, 0, 0, 1, 8'h8E, 8'h43, 0);
    tbl[15] = mk(0, 16'h0000, 0, 0, 1, 8'h8E, 8'h43, 0);
    tbl[16] = mk(0, 16'h0000, 1, 0, 1, 8'h8E, 8'h43, 0);
    tbl[17] = mk(0, 16'h0000, 0, 0, 1, 8'h43, 8'h8E, 0);
    tbl[18] = mk(0, 16'h0000, 1, 1, 1, 8'h43, 8'h8E, 0);
    tbl[19] = mk(0, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 0);

    rst = 1'b1;
    drive(0, 16'h0000, 0);
    @(negedge clk);
    check_idle_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].vld, tbl[i].w, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_prdy_be", i), {7'd0, rdy_be}, {7'd0, tbl[i].e_prdy});
      chk($sformatf("v%0d_prdy_le", i), {7'd0, rdy_le}, {7'd0, tbl[i].e_prdy});
      chk($sformatf("v%0d_bvld_be", i), {7'd0, vld_be}, {7'd0, tbl[i].e_bvld});
      chk($sformatf("v%0d_bvld_le", i), {7'd0, vld_le}, {7'd0, tbl[i].e_bvld});
      if (tbl[i].e_bvld) begin
        chk($sformatf("v%0d_dat_be", i), dat_be, tbl[i].e_be);
        chk($sformatf("v%0d_dat_le", i), dat_le, tbl[i].e_le);
      end
`ifdef RGB565_SER_LAST_EN
      chk($sformatf("v%0d_lst_be", i), {7'd0, lst_be}, {7'd0, tbl[i].e_lst});
      chk($sformatf("v%0d_lst_le", i), {7'd0, lst_le}, {7'd0, tbl[i].e_lst});
`endif
      @(posedge clk);
      #1;
    end

    // Reset while the first byte of a pixel is on the bus; line count is odd here.
    drive(1, 16'hABCD, 0);
    @(posedge clk);
    #1 drive(0, 16'h0000, 0);
    #1;
    chk("mid_b0_bvld", {7'd0, vld_be}, 8'd1);
    chk("mid_b0_dat", dat_be, 8'hAB);
    rst = 1'b1;
    #1;
    check_idle_reset("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_bvld", i), {7'd0, vld_be}, 8'd0);
      chk($sformatf("post_rst%0d_prdy", i), {7'd0, rdy_be}, 8'd1);
      @(posedge clk);
      #1;
    end

    // Randomised run; model is a queue of pending words plus which byte is next.
    half    = 0;
    pixdone = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        vld, rdy, e_bvld, e_prdy, e_lst, acc, bh;
      logic [15:0] w;
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      w   = 16'($urandom);
      drive(vld, w, rdy);
      @(negedge clk);
      e_bvld = (wq.size() != 0);
      e_prdy = !e_bvld || ((half == 1) && rdy);
      e_lst  = e_bvld && (half == 1) && ((pixdone % LinePx) == LinePx - 1);
      chk("rnd_prdy_be", {7'd0, rdy_be}, {7'd0, e_prdy});
      chk("rnd_prdy_le", {7'd0, rdy_le}, {7'd0, e_prdy});
      chk("rnd_bvld_be", {7'd0, vld_be}, {7'd0, e_bvld});
      chk("rnd_bvld_le", {7'd0, vld_le}, {7'd0, e_bvld});
      if (e_bvld) begin
        chk("rnd_dat_be", dat_be, byte_of(wq[0], 1'b1, half));
        chk("rnd_dat_le", dat_le, byte_of(wq[0], 1'b0, half));
      end
`ifdef RGB565_SER_LAST_EN
      chk("rnd_lst_be", {7'd0, lst_be}, {7'd0, e_lst});
      chk("rnd_lst_le", {7'd0, lst_le}, {7'd0, e_lst});
`endif
      acc = vld && e_prdy;
      bh  = e_bvld && rdy;
      @(posedge clk);
      if (bh) begin
        if (half == 0) begin
          half = 1;
        end else begin
          void'(wq.pop_front());
          half = 0;
          pixdone++;
        end
      end
      if (acc) wq.push_back(w);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
